pipelined_barrel_shifter: RTL and testbench

//  Parametrised, pipelined successor to the combinational ALU barrel shifter.

---
 rtl/pipelined_barrel_shifter.sv | 139 +++++++++++++
 tb/tb_pipelined_barrel_shifter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_barrel_shifter.sv
// Purpose: pipelined SLL/SRL/SRA/ROL/ROR on a WIDTH-bit operand, log-depth levels split over STAGES.
// Latency: exactly STAGES cycles from input transfer to out_valid, 1 op/cycle throughput.
// Backpressure: valid/ready per stage, in_ready combinational from out_ready (no skid); flush drops all.
module pipelined_barrel_shifter #(
  parameter  int WIDTH  = 32,
  parameter  int STAGES = 2,
  parameter  int TAGW   = 4,
  localparam int SHW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [2:0]       in_op,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAGW-1:0]  out_tag,
  output logic             out_zero,
  output logic             out_err
);

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  // Everything one operation needs on its way down the pipe.
  // sign is A[WIDTH-1], kept separately so SRA fill never depends on partial results.
  typedef struct packed {
    logic             vld;
    logic             err;
    logic             zero;
    logic             sign;
    logic [2:0]       op;
    logic [SHW-1:0]   shamt;
    logic [TAGW-1:0]  tag;
    logic [WIDTH-1:0] data;
  } stage_t;

  stage_t            st_q [STAGES];
  stage_t            st_d [STAGES];
  stage_t            prev [STAGES];
  stage_t            in_st;
  logic [STAGES-1:0] load;

  // One shifter level: move d by k bit positions according to op.
  function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] d,
                                                   input logic [2:0]       op,
                                                   input logic             sign,
                                                   input int               k);
    logic [WIDTH-1:0] r;
    r = d;
    case (op)
      OP_SLL:  r = d << k;
      OP_SRL:  r = d >> k;
      OP_SRA:  r = ({WIDTH{sign}} << (WIDTH - k)) | (d >> k);
      OP_ROL:  r = (d << k) | (d >> (WIDTH - k));
      OP_ROR:  r = (d >> k) | (d << (WIDTH - k));
      default: r = d;
    endcase
    return r;
  endfunction

  // Load enables ripple back from the output: a stage moves when empty or when its successor moves.
  always_comb begin
    logic nxt;
    load = '0;
    nxt  = ~st_q[STAGES-1].vld | out_ready;
    load[STAGES-1] = nxt;
    for (int k = STAGES - 2; k >= 0; k--) begin
      nxt     = ~st_q[k].vld | nxt;
      load[k] = nxt;
    end
    in_ready = load[0] & ~flush;
  end

  // Entry record; an illegal op enters as zero data so every level passes it through as zero.
  always_comb begin
    in_st       = '0;
    in_st.vld   = in_valid & in_ready;
    in_st.err   = (in_op > OP_ROR);
    in_st.sign  = in_st.err ? 1'b0 : in_data[WIDTH-1];
    in_st.op    = in_op;
    in_st.shamt = in_shamt;
    in_st.tag   = in_tag;
    in_st.data  = in_st.err ? '0 : in_data;
  end

  // Each stage's combinational input is the entry record or the previous stage register.
  for (genvar s = 0; s < STAGES; s++) begin : g_link
    if (s == 0) begin : g_head
      assign prev[s] = in_st;
    end else begin : g_tail
      assign prev[s] = st_q[s-1];
    end
  end

  // Stage s applies levels floor(s*SHW/STAGES) .. floor((s+1)*SHW/STAGES)-1 (level i shifts by 2^i).
  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      st_d[s] = prev[s];
      for (int i = 0; i < SHW; i++) begin
        if (i >= (s * SHW) / STAGES && i < ((s + 1) * SHW) / STAGES && prev[s].shamt[i]) begin
          st_d[s].data = shift_level(st_d[s].data, prev[s].op, prev[s].sign, 1 << i);
        end
      end
      st_d[s].zero = (st_d[s].data == '0);
    end
  end

  // Stage registers: payload only captured for real operations so stalled outputs hold still.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) st_q[s] <= '0;
    end else if (flush) begin
      for (int s = 0; s < STAGES; s++) st_q[s].vld <= 1'b0;
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (load[s]) begin
          if (st_d[s].vld) st_q[s] <= st_d[s];
          else             st_q[s].vld <= 1'b0;
        end
      end
    end
  end

  assign out_valid = st_q[STAGES-1].vld;
  assign out_data  = st_q[STAGES-1].data;
  assign out_tag   = st_q[STAGES-1].tag;
  assign out_zero  = st_q[STAGES-1].zero;
  assign out_err   = st_q[STAGES-1].err;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Purpose: scoreboard bench for pipelined_barrel_shifter (WIDTH=32, STAGES=2).
// Latency: expects results STAGES cycles after accept whenever out_ready is held high.
// Backpressure: exercises stalls, random out_ready, flush and async reset mid-flight.
module tb_pipelined_barrel_shifter;

  localparam int W   = 32;
  localparam int LAT = 2;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [4:0]    in_shamt;
  logic [2:0]    in_op;
  logic [3:0]    in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [3:0]    out_tag;
  logic          out_zero;
  logic          out_err;

  typedef struct {
    logic [W-1:0] data;
    logic [3:0]   tag;
    logic         err;
    logic         zero;
    int           acc;
  } exp_t;

  exp_t sc_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   seen   = 0;
  bit   chk_lat  = 1'b0;
  bit   rand_rdy = 1'b0;

  pipelined_barrel_shifter #(.WIDTH(W), .STAGES(LAT), .TAGW(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_zero(out_zero), .out_err(out_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got %0d cycles want < 50000", cyc);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
    end
  endtask

  // Reference: rotations as slices of a doubled word, SRA via sign-extended 64-bit shift.
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a,
                                 input logic [4:0] sh, input logic [3:0] tag);
    exp_t        e;
    logic [63:0] dbl;
    logic [63:0] sx;
    logic [63:0] t;
    dbl   = {a, a};
    sx    = {{32{a[31]}}, a};
    e.tag = tag;
    e.err = 1'b0;
    e.acc = 0;
    case (op)
      3'd0: e.data = a << sh;
      3'd1: e.data = a >> sh;
      3'd2: begin t = sx >> sh;  e.data = t[31:0];  end
      3'd3: begin t = dbl << sh; e.data = t[63:32]; end
      3'd4: begin t = dbl >> sh; e.data = t[31:0];  end
      default: begin e.data = '0; e.err = 1'b1; end
    endcase
    e.zero = (e.data == 32'd0);
    return e;
  endfunction

  // Present one op from a falling edge until accepted; expected result queued on acceptance.
  task automatic send(input logic [2:0] op, input logic [W-1:0] a,
                      input logic [4:0] sh, input logic [3:0] tag);
    exp_t e;
    in_valid = 1'b1;
    in_op    = op;
    in_data  = a;
    in_shamt = sh;
    in_tag   = tag;
    for (int t = 0; ; t++) begin
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (in_ready) begin
        e     = model(op, a, sh, tag);
        e.acc = cyc;
        sc_q.push_back(e);
        @(negedge clk);
        break;
      end
      if (t == 50) begin
        checks++;
        errors++;
        $display("FAIL send timeout: in_ready got 0 for %0d cycles want 1", t);
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 500 && sc_q.size() != 0; t++) begin
      @(negedge clk);
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
    chk("drain queue empty", 64'(sc_q.size()), 64'd0);
  endtask

  // Monitor: pops on every output transfer, checks held outputs during stalls.
  initial begin
    exp_t         e;
    bit           hold_vld;
    logic [W-1:0] hold_d;
    logic [3:0]   hold_t;
    logic         hold_z;
    logic         hold_e;
    hold_vld = 1'b0;
    hold_d = '0; hold_t = '0; hold_z = 1'b0; hold_e = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && !flush) begin
        if (hold_vld) begin
          chk("stall hold valid", 64'(out_valid), 64'd1);
          chk("stall hold data/tag/flags", {26'd0, out_data, out_tag, out_zero, out_err},
              {26'd0, hold_d, hold_t, hold_z, hold_e});
        end
        hold_vld = 1'b0;
        if (out_valid) begin
          if (out_ready) begin
            seen++;
            if (sc_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected result: got tag %0d data 0x%0h want no output", out_tag, out_data);
            end else begin
              e = sc_q.pop_front();
              chk("result data", 64'(out_data), 64'(e.data));
              chk("result tag", 64'(out_tag), 64'(e.tag));
              chk("result err", 64'(out_err), 64'(e.err));
              chk("result zero", 64'(out_zero), 64'(e.zero));
              if (chk_lat) chk("latency", 64'(cyc - e.acc), 64'(LAT));
            end
          end else begin
            hold_vld = 1'b1;
            hold_d = out_data; hold_t = out_tag; hold_z = out_zero; hold_e = out_err;
          end
        end
      end else begin
        hold_vld = 1'b0;
      end
    end
  end

  initial begin
    int base;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_data = '0; in_shamt = '0; in_op = '0; in_tag = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("reset out_valid", 64'(out_valid), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("post-reset in_ready", 64'(in_ready), 64'd1);
    chk("post-reset out_valid", 64'(out_valid), 64'd0);
    chk("post-reset outputs", {27'd0, out_data, out_tag, out_zero, out_err}, 64'd0);
    @(negedge clk);

    // T1/T2/T3/T5: directed ops with out_ready held high, latency checked
    chk_lat = 1'b1;
    send(3'd0, 32'h0000_00F1, 5'd4, 4'd1);
    send(3'd0, 32'h1234_5678, 5'd0, 4'd2);
    send(3'd2, 32'h8000_0000, 5'd31, 4'd3);
    send(3'd1, 32'h8000_0000, 5'd31, 4'd4);
    send(3'd4, 32'h0000_0001, 5'd1, 4'd5);
    send(3'd3, 32'h8000_0001, 5'd4, 4'd6);
    send(3'd0, 32'h0000_0001, 5'd31, 4'd7);
    send(3'd2, 32'h7FFF_FFFF, 5'd31, 4'd8);
    send(3'd3, 32'hA5A5_0F0F, 5'd0, 4'd9);
    send(3'd7, 32'hDEAD_BEEF, 5'd3, 4'd10);
    send(3'd1, 32'hDEAD_BEEF, 5'd8, 4'd11);
    send(3'd5, 32'h0000_0000, 5'd0, 4'd12);
    send(3'd1, 32'hFFFF_FFFF, 5'd31, 4'd13);
    drain();

    // T4: stalled consumer, capacity two, order preserved on release
    chk_lat = 1'b0;
    out_ready = 1'b0;
    send(3'd0, 32'h0000_0011, 5'd1, 4'd0);
    send(3'd1, 32'h0000_0022, 5'd1, 4'd1);
    in_valid = 1'b1; in_op = 3'd3; in_data = 32'h0000_0033; in_shamt = 5'd1; in_tag = 4'd2;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("full pipe in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    send(3'd3, 32'h0000_0033, 5'd1, 4'd2);
    send(3'd4, 32'h0000_0044, 5'd1, 4'd3);
    drain();

    // T6a: async reset with two ops in flight
    out_ready = 1'b0;
    send(3'd0, 32'h0000_0101, 5'd2, 4'd4);
    send(3'd0, 32'h0000_0202, 5'd2, 4'd5);
    #1;
    chk("pre-reset out_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async reset drops out_valid", 64'(out_valid), 64'd0);
    sc_q.delete();
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    base = seen;
    repeat (6) @(negedge clk);
    #1;
    chk("no stale result after reset", 64'(seen - base), 64'd0);
    chk("idle after reset out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);

    // T6b: flush with two ops in flight plus same-cycle input/output attempts
    out_ready = 1'b0;
    send(3'd1, 32'h0000_0F00, 5'd4, 4'd6);
    send(3'd1, 32'h0000_F000, 5'd4, 4'd7);
    #1;
    chk("pre-flush out_valid", 64'(out_valid), 64'd1);
    flush = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = 3'd0; in_data = 32'h0000_0005; in_shamt = 5'd1; in_tag = 4'd8;
    #1;
    chk("flush in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    sc_q.delete();
    base = seen;
    repeat (6) @(negedge clk);
    #1;
    chk("no result after flush", 64'(seen - base), 64'd0);
    chk("idle after flush out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk_lat = 1'b1;
    send(3'd4, 32'h0000_00F0, 5'd4, 4'd9);
    drain();

    // Randomised ops with random consumer stalls and input gaps
    chk_lat = 1'b0;
    rand_rdy = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
      end
      send(3'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)));
    end
    drain();
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
